dram_preload_ctrl: RTL
======================

Name: dram_preload_ctrl

Overview:
Sequences the initial DRAM image load over the SoC's wide AXI write path before the Ara/Ariane system leaves reset. It accepts a stream of memory rows from a loader (host bridge or debug port), packs contiguous rows into AXI4 INCR write bursts, and tracks write responses. It holds the core reset low until the final burst is acknowledged. It sits between the loader and the DRAM slave port and is the only writer of DRAM during preload.

Parameters:
AxiAddrWidth, 64, address width
AxiDataWidth, 256, data width (64*NrLanes/2); BeBytes = AxiDataWidth/8
MaxBurstLen, 16, max beats per burst, power of two, 1..256
DRAMAddrBase, 64'h8000_0000, first valid DRAM byte address
DRAMLength, 64'h4000_0000, DRAM size in bytes

Ports:
clk_i  in  1  clock
rst_ni  in  1  asynchronous active-low reset
ld_valid_i  in  1  loader row valid
ld_ready_o  out  1  loader row accepted
ld_addr_i  in  AxiAddrWidth  row byte address, BeBytes-aligned
ld_data_i  in  AxiDataWidth  row data
ld_last_i  in  1  last row of image
aw_valid_o / aw_ready_i  out/in  1  AW handshake
aw_addr_o  out  AxiAddrWidth  burst start address
aw_len_o  out  8  beats-1
aw_size_o  out  3  log2(BeBytes)
aw_burst_o  out  2  constant 2'b01 (INCR)
w_valid_o / w_ready_i  out/in  1  W handshake
w_data_o  out  AxiDataWidth  beat data
w_strb_o  out  BeBytes  all ones
w_last_o  out  1  final beat of burst
b_valid_i / b_ready_o  in/out  1  B handshake
b_resp_i  in  2  write response
core_rst_no  out  1  system reset, low until preload done
done_o  out  1  preload complete
drop_cnt_o  out  16  out-of-range rows dropped, saturating
bresp_err_o  out  1  sticky, any non-OKAY response

Behaviour:
- Reset (async): state IDLE; all valids 0; b_ready_o 0; ld_ready_o 0 while rst_ni low; core_rst_no 0; done_o 0; drop_cnt_o 0; bresp_err_o 0; beat buffer contents don't-care.
- In range: DRAMAddrBase <= addr < DRAMAddrBase+DRAMLength.
- IDLE: ld_ready_o=1. Accepted out-of-range row: discarded, drop_cnt +1 (saturate 0xFFFF); if ld_last_i, seen_last set and go DONE. Accepted in-range row: buf[0]=data, base=addr, cnt=1, seen_last=ld_last_i. Go FILL, or AW if ld_last_i.
- FILL: next=base+cnt*BeBytes. A valid row is contiguous iff in range and ld_addr_i==next. ld_ready_o = cnt<MaxBurstLen && (!ld_valid_i || contiguous). Ready may depend on valid/addr; valid must not depend on ready. Accepted row: buf[cnt]=data, cnt+1.
- Close burst (go AW next cycle) when any of: cnt reaches MaxBurstLen; valid non-contiguous row presented (not accepted, retried from IDLE); accepted row has ld_last_i; next[11:0]==0 (4 KiB boundary, no AXI crossing).
- AW: aw_valid_o=1, aw_addr_o=base, aw_len_o=cnt-1. All fields stable until aw_ready_i. Handshake -> W, idx=0.
- W: w_valid_o=1, w_data_o=buf[idx], w_last_o=(idx==cnt-1). Stable until w_ready_i. W is never issued before the AW handshake. Last handshake -> B.
- B: b_ready_o=1. On b_valid_i: b_resp_i!=2'b00 sets bresp_err_o. Then seen_last ? DONE : IDLE. One burst outstanding at a time.
- DONE: terminal until reset. done_o=1, core_rst_no=1 (registered, glitch-free), ld_ready_o=0.
- Latency: last row accept -> aw_valid_o next cycle. B handshake in last burst -> done_o/core_rst_no next cycle.
- Reset mid-burst: immediate abort, all outputs to reset values. The interconnect is reset together with this block.
- Rows after ld_last_i are never accepted.

Test Plan:
- AxiDataWidth=256: 3 rows 0x8000_0000/20/40, last on third -> one AW addr 0x8000_0000 len 2 size 5; 3 W beats, w_last on third. B OKAY -> done_o=1, core_rst_no=1 one cycle later.
- 20 contiguous rows from 0x8000_0000 -> AW len 15 @0x8000_0000, then AW len 3 @0x8000_0200. Data order preserved.
- Rows 0x8000_0FC0, 0x8000_0FE0, 0x8000_1000(last) -> bursts len 1 @0x8000_0FC0 and len 0 @0x8000_1000.
- Row 0x7FFF_FFE0 then 0x8000_0000(last) -> drop_cnt_o=1. Single burst len 0 @0x8000_0000.
- Non-contiguous 0x8000_0000 then 0x8000_0100(last) -> two bursts len 0. B of first = SLVERR -> bresp_err_o=1, done_o still asserts after second B.
- Hold aw_ready_i/w_ready_i low 5 cycles -> fields stable. Assert rst_ni low during W -> next edge all valids 0, core_rst_no 0, state IDLE.

Source files
------------

// File: rtl/dram_preload_ctrl_if.sv
// dram_preload_ctrl_if
// Handshake bundle around the DRAM preload controller: the loader row stream
// (ld_*) and the AXI4 write address / data / response channels (aw_*, w_*, b_*).
// Signal suffixes are relative to the controller.
//   modport master : controller side (accepts rows, issues AXI writes)
//   modport slave  : environment side (loader + DRAM slave port)
interface dram_preload_ctrl_if #(
   parameter int unsigned AxiAddrWidth = 64,
   parameter int unsigned AxiDataWidth = 256
);
   localparam int unsigned BeBytes = AxiDataWidth / 8;

   logic                    ld_valid_i;
   logic                    ld_ready_o;
   logic [AxiAddrWidth-1:0] ld_addr_i;
   logic [AxiDataWidth-1:0] ld_data_i;
   logic                    ld_last_i;

   logic                    aw_valid_o;
   logic                    aw_ready_i;
   logic [AxiAddrWidth-1:0] aw_addr_o;
   logic [7:0]              aw_len_o;
   logic [2:0]              aw_size_o;
   logic [1:0]              aw_burst_o;

   logic                    w_valid_o;
   logic                    w_ready_i;
   logic [AxiDataWidth-1:0] w_data_o;
   logic [BeBytes-1:0]      w_strb_o;
   logic                    w_last_o;

   logic                    b_valid_i;
   logic                    b_ready_o;
   logic [1:0]              b_resp_i;

   modport master (
      input  ld_valid_i, ld_addr_i, ld_data_i, ld_last_i,
      output ld_ready_o,
      output aw_valid_o, aw_addr_o, aw_len_o, aw_size_o, aw_burst_o,
      input  aw_ready_i,
      output w_valid_o, w_data_o, w_strb_o, w_last_o,
      input  w_ready_i,
      input  b_valid_i, b_resp_i,
      output b_ready_o
   );

   modport slave (
      output ld_valid_i, ld_addr_i, ld_data_i, ld_last_i,
      input  ld_ready_o,
      input  aw_valid_o, aw_addr_o, aw_len_o, aw_size_o, aw_burst_o,
      output aw_ready_i,
      input  w_valid_o, w_data_o, w_strb_o, w_last_o,
      output w_ready_i,
      output b_valid_i, b_resp_i,
      input  b_ready_o
   );
endinterface

// File: rtl/dram_preload_ctrl.sv
// dram_preload_ctrl
// Loads the initial DRAM image before the core leaves reset. Rows from the
// loader are packed into AXI4 INCR write bursts (contiguous, in DRAM range,
// never crossing 4 KiB, at most MaxBurstLen beats); one burst is outstanding
// at a time. Out-of-range rows are dropped and counted. The core reset is
// released only after the burst holding the last row is acknowledged.
// Ports:
//   clk_i, rst_ni  clock, asynchronous active-low reset
//   bus            loader + AXI write channels (dram_preload_ctrl_if.master)
//   core_rst_no    system reset, low until preload done (registered)
//   done_o         preload complete
//   drop_cnt_o     out-of-range rows dropped, saturating
//   bresp_err_o    sticky, any non-OKAY write response
//
// state | meaning
// IDLE  | waiting for the first row of a burst
// FILL  | collecting contiguous rows into the beat buffer
// AW    | presenting the burst address
// W     | streaming buffered beats
// B     | waiting for the write response
// DONE  | image loaded, core released (terminal until reset)
module dram_preload_ctrl #(
   parameter int unsigned                AxiAddrWidth = 64,
   parameter int unsigned                AxiDataWidth = 256,
   parameter int unsigned                MaxBurstLen  = 16,
   parameter logic [AxiAddrWidth-1:0]    DRAMAddrBase = 'h8000_0000,
   parameter logic [AxiAddrWidth-1:0]    DRAMLength   = 'h4000_0000
) (
   input  logic                clk_i,
   input  logic                rst_ni,
   dram_preload_ctrl_if.master bus,
   output logic                core_rst_no,
   output logic                done_o,
   output logic [15:0]         drop_cnt_o,
   output logic                bresp_err_o
);

   localparam int unsigned BeBytes  = AxiDataWidth / 8;
   localparam int unsigned SizeLog2 = $clog2(BeBytes);
   localparam int unsigned CntW     = $clog2(MaxBurstLen + 1);
   localparam int unsigned IdxW     = (MaxBurstLen > 1) ? $clog2(MaxBurstLen) : 1;
   localparam logic [AxiAddrWidth-1:0] DramEnd  = DRAMAddrBase + DRAMLength;
   localparam logic [AxiAddrWidth-1:0] RowBytes = AxiAddrWidth'(BeBytes);
   localparam logic [CntW-1:0]         MaxCnt   = CntW'(MaxBurstLen);

   typedef enum logic [2:0] {IDLE, FILL, AW, W, B, DONE} state_e;

   state_e                  state_q;
   logic [AxiAddrWidth-1:0] base_q;
   logic [CntW-1:0]         cnt_q;
   logic [CntW-1:0]         idx_q;
   logic                    seen_last_q;
   logic                    aw_valid_q;
   logic                    w_valid_q;
   logic                    w_last_q;
   logic                    b_ready_q;
   logic                    done_q;
   logic                    core_rst_q;
   logic [15:0]             drop_cnt_q;
   logic                    bresp_err_q;

   logic [AxiDataWidth-1:0] beat_buf [MaxBurstLen];

   logic                    in_range;
   logic                    contig;
   logic                    ld_ready;
   logic                    ld_fire;
   logic [AxiAddrWidth-1:0] next_addr;
   logic [AxiAddrWidth-1:0] after_addr;
   logic [AxiAddrWidth-1:0] first_next;
   logic [CntW-1:0]         cnt_inc;
   logic [IdxW-1:0]         wr_idx;

   assign in_range   = (bus.ld_addr_i >= DRAMAddrBase) && (bus.ld_addr_i < DramEnd);
   assign next_addr  = base_q + (AxiAddrWidth'(cnt_q) << SizeLog2);
   assign after_addr = next_addr + RowBytes;
   assign first_next = bus.ld_addr_i + RowBytes;
   assign contig     = in_range && (bus.ld_addr_i == next_addr);
   assign cnt_inc    = cnt_q + CntW'(1);
   assign ld_fire    = bus.ld_valid_i && ld_ready;
   assign wr_idx     = (state_q == FILL) ? cnt_q[IdxW-1:0] : '0;

   // Ready is combinational on valid/addr so a non-contiguous row is simply
   // left pending and re-offered once the current burst has been written.
   always_comb begin
      ld_ready = 1'b0;
      if (rst_ni) begin
         case (state_q)
            IDLE:    ld_ready = 1'b1;
            FILL:    ld_ready = (cnt_q < MaxCnt) && (!bus.ld_valid_i || contig);
            default: ld_ready = 1'b0;
         endcase
      end
   end

   always_ff @(posedge clk_i) begin
      if (ld_fire) begin
         beat_buf[wr_idx] <= bus.ld_data_i;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q     <= IDLE;
         base_q      <= '0;
         cnt_q       <= '0;
         idx_q       <= '0;
         seen_last_q <= 1'b0;
         aw_valid_q  <= 1'b0;
         w_valid_q   <= 1'b0;
         w_last_q    <= 1'b0;
         b_ready_q   <= 1'b0;
         done_q      <= 1'b0;
         core_rst_q  <= 1'b0;
         drop_cnt_q  <= '0;
         bresp_err_q <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               if (ld_fire) begin
                  if (!in_range) begin
                     if (drop_cnt_q != 16'hFFFF) drop_cnt_q <= drop_cnt_q + 16'd1;
                     if (bus.ld_last_i) begin
                        seen_last_q <= 1'b1;
                        done_q      <= 1'b1;
                        core_rst_q  <= 1'b1;
                        state_q     <= DONE;
                     end
                  end else begin
                     base_q      <= bus.ld_addr_i;
                     cnt_q       <= CntW'(1);
                     seen_last_q <= bus.ld_last_i;
                     // A single-row burst also closes at a 4 KiB edge or when bursts are 1 beat.
                     if (bus.ld_last_i || (MaxCnt == CntW'(1)) || (first_next[11:0] == 12'h000)) begin
                        aw_valid_q <= 1'b1;
                        state_q    <= AW;
                     end else begin
                        state_q <= FILL;
                     end
                  end
               end
            end
            FILL: begin
               if (ld_fire) begin
                  cnt_q       <= cnt_inc;
                  seen_last_q <= bus.ld_last_i;
                  if (bus.ld_last_i || (cnt_inc == MaxCnt) || (after_addr[11:0] == 12'h000)) begin
                     aw_valid_q <= 1'b1;
                     state_q    <= AW;
                  end
               end else if (bus.ld_valid_i && !contig) begin
                  aw_valid_q <= 1'b1;
                  state_q    <= AW;
               end
            end
            AW: begin
               if (bus.aw_ready_i) begin
                  aw_valid_q <= 1'b0;
                  w_valid_q  <= 1'b1;
                  idx_q      <= '0;
                  w_last_q   <= (cnt_q == CntW'(1));
                  state_q    <= W;
               end
            end
            W: begin
               if (bus.w_ready_i) begin
                  if (w_last_q) begin
                     w_valid_q <= 1'b0;
                     w_last_q  <= 1'b0;
                     b_ready_q <= 1'b1;
                     state_q   <= B;
                  end else begin
                     idx_q    <= idx_q + CntW'(1);
                     w_last_q <= ((idx_q + CntW'(2)) == cnt_q);
                  end
               end
            end
            B: begin
               if (bus.b_valid_i) begin
                  b_ready_q <= 1'b0;
                  if (bus.b_resp_i != 2'b00) bresp_err_q <= 1'b1;
                  if (seen_last_q) begin
                     done_q     <= 1'b1;
                     core_rst_q <= 1'b1;
                     state_q    <= DONE;
                  end else begin
                     state_q <= IDLE;
                  end
               end
            end
            DONE: begin
               state_q <= DONE;
            end
            default: begin
               state_q <= IDLE;
            end
         endcase
      end
   end

   assign bus.ld_ready_o = ld_ready;
   assign bus.aw_valid_o = aw_valid_q;
   assign bus.aw_addr_o  = base_q;
   assign bus.aw_len_o   = 8'(cnt_q - CntW'(1));
   assign bus.aw_size_o  = 3'(SizeLog2);
   assign bus.aw_burst_o = 2'b01;
   assign bus.w_valid_o  = w_valid_q;
   assign bus.w_data_o   = beat_buf[idx_q[IdxW-1:0]];
   assign bus.w_strb_o   = '1;
   assign bus.w_last_o   = w_last_q;
   assign bus.b_ready_o  = b_ready_q;

   assign core_rst_no = core_rst_q;
   assign done_o      = done_q;
   assign drop_cnt_o  = drop_cnt_q;
   assign bresp_err_o = bresp_err_q;

endmodule
